// File: rtl/alu_cmd_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module   : alu_cmd_sequencer                                                |
// | Purpose  : FIFO-buffered command sequencer driving an 8-bit accumulator ALU |
// |            with a valid/ready result port and zero/carry flags.             |
// | Options  : ALU_SEQ_SATURATE_EN - ADD/SUB clamp instead of wrapping.         |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [2:0] i_cmd_op,
    input  logic [7:0] i_cmd_data,
    output logic       o_res_valid,
    input  logic       i_res_ready,
    output logic [7:0] o_res_data,
    output logic       o_zero,
    output logic       o_carry,
    output logic       o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_OP_OR   = 3'b000;
    localparam logic [2:0] c_OP_NAND = 3'b001;
    localparam logic [2:0] c_OP_NOR  = 3'b010;
    localparam logic [2:0] c_OP_AND  = 3'b011;
    localparam logic [2:0] c_OP_ADD  = 3'b100;
    localparam logic [2:0] c_OP_SUB  = 3'b101;
    localparam logic [2:0] c_OP_LOAD = 3'b110;
    localparam logic [2:0] c_OP_EMIT = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [10:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [10:0]      w_head;
    logic [2:0]       w_head_op;
    logic [7:0]       w_head_b;
    logic             w_head_emit;
    logic             w_emit_fire;
    logic [8:0]       w_sum;
    logic [8:0]       w_diff;
    logic [7:0]       w_alu;
    logic             w_cout;

    assign w_full      = (count_q == c_CNT_FULL);
    assign w_empty     = (count_q == c_CNT_ZERO);
    assign w_push      = i_cmd_valid && !w_full;
    assign w_head      = fifo_mem_q[rd_ptr_q];
    assign w_head_op   = w_head[10:8];
    assign w_head_b    = w_head[7:0];
    assign w_head_emit = (w_head_op == c_OP_EMIT);
    assign w_emit_fire = w_pop && w_head_emit;

    assign o_cmd_ready = !w_full;
    assign o_res_valid = res_valid_q;
    assign o_res_data  = res_data_q;
    assign o_zero      = zero_q;
    assign o_carry     = carry_q;
    assign o_busy      = !w_empty || (state_q != S_IDLE);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!w_pop && !w_empty)      state_d = S_STALL;
                else if (count_d == c_CNT_ZERO) state_d = S_IDLE;
                else                         state_d = S_EXEC;
            end
            S_STALL: begin
                if (w_pop) state_d = (count_d == c_CNT_ZERO) ? S_IDLE : S_EXEC;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // An EMIT may only retire once the previous result has been taken.
    always_comb begin
        w_pop = 1'b0;
        case (state_q)
            S_EXEC:  w_pop = !w_empty && !(w_head_emit && res_valid_q && !i_res_ready);
            S_STALL: w_pop = !w_empty && i_res_ready;
            default: w_pop = 1'b0;
        endcase
    end

    // ----------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (w_push) fifo_mem_q[wr_ptr_q] <= {i_cmd_op, i_cmd_data};
    end

    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------ ALU
    assign w_sum  = {1'b0, acc_q} + {1'b0, w_head_b};
    assign w_diff = {1'b0, w_head_b} - {1'b0, acc_q};

    always_comb begin
        w_alu  = acc_q;
        w_cout = 1'b0;
        case (w_head_op)
            c_OP_OR:   w_alu = acc_q | w_head_b;
            c_OP_NAND: w_alu = ~(acc_q & w_head_b);
            c_OP_NOR:  w_alu = ~(acc_q | w_head_b);
            c_OP_AND:  w_alu = acc_q & w_head_b;
            c_OP_ADD: begin
                w_cout = w_sum[8];
`ifdef ALU_SEQ_SATURATE_EN
                w_alu  = w_sum[8] ? 8'hFF : w_sum[7:0];
`else
                w_alu  = w_sum[7:0];
`endif
            end
            c_OP_SUB: begin
                // Bit 8 of the 9-bit difference is set exactly when acc > B.
                w_cout = w_diff[8];
`ifdef ALU_SEQ_SATURATE_EN
                w_alu  = w_diff[8] ? 8'h00 : w_diff[7:0];
`else
                w_alu  = w_diff[7:0];
`endif
            end
            c_OP_LOAD: w_alu = w_head_b;
            default:   w_alu = acc_q;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        if (w_pop && !w_head_emit) begin
            acc_d   = w_alu;
            zero_d  = (w_alu == 8'h00);
            carry_d = w_cout;
        end
        if (w_emit_fire) begin
            res_data_d  = acc_q;
            res_valid_d = 1'b1;
        end else if (i_res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= 8'h00;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_alu_cmd_sequencer                                             |
// | Purpose  : Directed self-checking bench for alu_cmd_sequencer.              |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_EMIT = 3'b111;

`ifdef ALU_SEQ_SATURATE_EN
    localparam logic [7:0] EXP_ADD   = 8'hFF;
    localparam logic [7:0] EXP_SUB   = 8'h00;
    localparam logic       EXP_SUB_Z = 1'b1;
`else
    localparam logic [7:0] EXP_ADD   = 8'h10;
    localparam logic [7:0] EXP_SUB   = 8'hFE;
    localparam logic       EXP_SUB_Z = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [2:0] i_cmd_op;
    logic [7:0] i_cmd_data;
    logic       o_res_valid;
    logic       i_res_ready;
    logic [7:0] o_res_data;
    logic       o_zero;
    logic       o_carry;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_data  (i_cmd_data),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_data  (o_res_data),
        .o_zero      (o_zero),
        .o_carry     (o_carry),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; one call = one accepted command.
    task automatic push_cmd(input logic [2:0] op, input logic [7:0] data);
        int n = 0;
        while (!o_cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_data  = data;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic get_result(output bit ok, output logic [7:0] d,
                              output logic z, output logic c, output logic b);
        int n = 0;
        while (!o_res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = o_res_valid;
        d  = o_res_data;
        z  = o_zero;
        c  = o_carry;
        b  = o_busy;
        i_res_ready = 1'b1;
        @(posedge clk); #1;
        i_res_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_res_valid, o_res_data, o_zero, o_carry, o_busy, o_cmd_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h z=%b c=%b busy=%b rdy=%b, expected 0 00 0 0 0 1",
                     o_res_valid, o_res_data, o_zero, o_carry, o_busy, o_cmd_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_logic_or();
        bit ok; logic [7:0] d; logic z, c, b;
        push_cmd(OP_LOAD, 8'h3C);
        push_cmd(OP_OR,   8'h81);
        push_cmd(OP_EMIT, 8'h00);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL or_busy_active: got %b expected 1", o_busy);
        end
        get_result(ok, d, z, c, b);
        checks++;
        if (!ok || d !== 8'hBD) begin
            errors++; $display("FAIL or_result: got valid=%b data=%h expected 1 BD", ok, d);
        end
        checks++;
        if (z !== 1'b0 || c !== 1'b0) begin
            errors++; $display("FAIL or_flags: got z=%b c=%b expected 0 0", z, c);
        end
        checks++;
        if (b !== 1'b0) begin
            errors++; $display("FAIL or_busy_drop: got %b expected 0", b);
        end
    endtask

    task automatic test_add_carry();
        bit ok; logic [7:0] d; logic z, c, b;
        push_cmd(OP_LOAD, 8'hF0);
        push_cmd(OP_ADD,  8'h20);
        push_cmd(OP_EMIT, 8'h00);
        get_result(ok, d, z, c, b);
        checks++;
        if (!ok || d !== EXP_ADD) begin
            errors++; $display("FAIL add_result: got valid=%b data=%h expected 1 %h", ok, d, EXP_ADD);
        end
        checks++;
        if (c !== 1'b1 || z !== 1'b0) begin
            errors++; $display("FAIL add_flags: got z=%b c=%b expected 0 1", z, c);
        end
    endtask

    task automatic test_sub_borrow();
        bit ok; logic [7:0] d; logic z, c, b;
        push_cmd(OP_LOAD, 8'h05);
        push_cmd(OP_SUB,  8'h03);
        push_cmd(OP_EMIT, 8'h00);
        get_result(ok, d, z, c, b);
        checks++;
        if (!ok || d !== EXP_SUB) begin
            errors++; $display("FAIL sub_result: got valid=%b data=%h expected 1 %h", ok, d, EXP_SUB);
        end
        checks++;
        if (c !== 1'b1 || z !== EXP_SUB_Z) begin
            errors++; $display("FAIL sub_flags: got z=%b c=%b expected %b 1", z, c, EXP_SUB_Z);
        end
    endtask

    task automatic test_full_stall();
        int         accepted;
        int         got;
        logic [7:0] r [3];
        bit ok; logic [7:0] d; logic z, c, b;
        wait_idle();
        i_res_ready = 1'b0;
        push_cmd(OP_LOAD, 8'h22);
        push_cmd(OP_EMIT, 8'h00);
        push_cmd(OP_LOAD, 8'h11);
        push_cmd(OP_EMIT, 8'h00);
        accepted = 4;
        for (int i = 0; i < 8; i++) begin
            if (!o_cmd_ready) break;
            i_cmd_valid = 1'b1;
            case (i)
                0:       begin i_cmd_op = OP_LOAD; i_cmd_data = 8'h33; end
                1:       begin i_cmd_op = OP_EMIT; i_cmd_data = 8'h00; end
                2:       begin i_cmd_op = OP_LOAD; i_cmd_data = 8'h44; end
                default: begin i_cmd_op = OP_LOAD; i_cmd_data = 8'h77; end
            endcase
            @(posedge clk); #1;
            i_cmd_valid = 1'b0;
            accepted++;
        end
        // Three commands retire before the second EMIT stalls, then four fill the FIFO.
        checks++;
        if (accepted != 7) begin
            errors++; $display("FAIL full_accept_count: got %0d expected 7", accepted);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_res_valid !== 1'b1 || o_res_data !== 8'h22 || o_cmd_ready !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h rdy=%b busy=%b expected 1 22 0 1",
                         k, o_res_valid, o_res_data, o_cmd_ready, o_busy);
            end
            @(posedge clk); #1;
        end
        i_res_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 30 && got < 3; n++) begin
            @(negedge clk);
            if (o_res_valid) begin
                r[got] = o_res_data;
                got++;
            end
        end
        @(posedge clk); #1;
        i_res_ready = 1'b0;
        checks++;
        if (got != 3) begin
            errors++; $display("FAIL drain_count: got %0d expected 3", got);
        end else begin
            checks++;
            if (r[0] !== 8'h22 || r[1] !== 8'h11 || r[2] !== 8'h33) begin
                errors++; $display("FAIL drain_order: got %h %h %h expected 22 11 33", r[0], r[1], r[2]);
            end
        end
        push_cmd(OP_EMIT, 8'h00);
        get_result(ok, d, z, c, b);
        checks++;
        if (!ok || d !== 8'h44) begin
            errors++; $display("FAIL drain_tail: got valid=%b data=%h expected 1 44", ok, d);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [7:0] d; logic z, c, b;
        wait_idle();
        push_cmd(OP_LOAD, 8'h0F);
        push_cmd(OP_ADD,  8'h01);
        push_cmd(OP_OR,   8'h05);
        push_cmd(OP_AND,  8'h1C);
        push_cmd(OP_NAND, 8'hF0);
        push_cmd(OP_NOR,  8'h10);
        push_cmd(OP_SUB,  8'h30);
        push_cmd(OP_EMIT, 8'h00);
        checks++;
        if (o_res_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_early0: got valid=%b expected 0", o_res_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (o_res_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_early1: got valid=%b expected 0", o_res_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (o_res_valid !== 1'b1 || o_res_data !== 8'h30) begin
            errors++; $display("FAIL b2b_result: got valid=%b data=%h expected 1 30", o_res_valid, o_res_data);
        end
        get_result(ok, d, z, c, b);
        checks++;
        if (z !== 1'b0 || c !== 1'b0) begin
            errors++; $display("FAIL b2b_flags: got z=%b c=%b expected 0 0", z, c);
        end
    endtask

    task automatic test_reset_midop();
        bit ok; logic [7:0] d; logic z, c, b;
        wait_idle();
        i_res_ready = 1'b0;
        push_cmd(OP_LOAD, 8'h55);
        push_cmd(OP_EMIT, 8'h00);
        push_cmd(OP_EMIT, 8'h00);
        push_cmd(OP_LOAD, 8'h66);
        push_cmd(OP_EMIT, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_res_valid !== 1'b1 || o_res_data !== 8'h55 || o_busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got valid=%b data=%h busy=%b expected 1 55 1",
                               o_res_valid, o_res_data, o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_res_valid, o_res_data, o_zero, o_carry, o_busy, o_cmd_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h z=%b c=%b busy=%b rdy=%b, expected 0 00 0 0 0 1",
                     o_res_valid, o_res_data, o_zero, o_carry, o_busy, o_cmd_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got valid=%b busy=%b expected 0 0", o_res_valid, o_busy);
        end
        push_cmd(OP_EMIT, 8'h00);
        get_result(ok, d, z, c, b);
        checks++;
        if (!ok || d !== 8'h00 || c !== 1'b0) begin
            errors++; $display("FAIL post_reset_emit: got valid=%b data=%h c=%b expected 1 00 0", ok, d, c);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 3'b000;
        i_cmd_data  = 8'h00;
        i_res_ready = 1'b0;
        test_reset();
        test_logic_or();
        test_add_carry();
        test_sub_borrow();
        test_full_stall();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
